// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  // Sequencer states: waiting for an op, counting unit latency, committing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } hilo_state_t;

  // unit_op encodings, {IsDiv, Signed}.
  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  // Latency counter width; covers parameter values up to 63.
  localparam int HILO_CNT_W = 6;

  // Build the unit opcode from the decoded EX flags.
  function automatic logic [1:0] hilo_op(input logic is_div, input logic is_signed);
    return {is_div, is_signed};
  endfunction

endpackage

// File: rtl/hilo_cycle_counter.sv
// hilo_cycle_counter: loadable down-counter with a zero flag, used to time
// the multiply/divide unit latency. Synchronous active-low reset clears it.
module hilo_cycle_counter
  import hilo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [HILO_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic [HILO_CNT_W-1:0] cnt,
  output logic                  zero
);

  logic [HILO_CNT_W-1:0] cnt_reg;
  logic [HILO_CNT_W-1:0] cnt_next;

  // Next count: a load wins over a decrement; never wraps below zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/hilo_scheduler.sv
// hilo_scheduler: launches the multi-cycle mult/div unit, times its latency,
// commits the result to HI/LO and stalls dependent instructions in ID.
// Optional macro HILO_EARLY_DONE_EN: lets unit_done end BUSY early.
module hilo_scheduler
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID2EX_MulDiv,
  input  logic       ID2EX_IsDiv,
  input  logic       ID2EX_Signed,
  input  logic       IF2ID_ReadHiLo,
  input  logic       IF2ID_WriteHiLo,
  input  logic       IF2ID_MulDiv,
  input  logic       unit_done,
  output logic       unit_start,
  output logic [1:0] unit_op,
  output logic       hilo_we,
  output logic       busy,
  output logic       stall
);

  // Counter preload is N-1 so the count hits zero on the N-th BUSY cycle.
  localparam logic [HILO_CNT_W-1:0] MUL_LOAD = HILO_CNT_W'(MUL_CYCLES - 1);
  localparam logic [HILO_CNT_W-1:0] DIV_LOAD = HILO_CNT_W'(DIV_CYCLES - 1);

  hilo_state_t           state_reg;
  hilo_state_t           state_next;
  logic                  ready_reg;
  logic                  start_next;
  logic [1:0]            op_next;
  logic                  we_next;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [HILO_CNT_W-1:0] cnt_load_val;
  logic [HILO_CNT_W-1:0] cnt;
  logic                  cnt_zero;
  logic                  early_done;
  logic                  dep_in_id;

`ifdef HILO_EARLY_DONE_EN
  assign early_done = unit_done;
`else
  // Completion is purely count-based; the unit's flag is intentionally dropped.
  logic unused_unit_done;
  assign unused_unit_done = unit_done;
  assign early_done       = 1'b0;
`endif

  hilo_cycle_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register; ready_reg keeps launches off for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
    end
  end

  // Next-state, launch and commit decode.
  always_comb begin
    state_next   = state_reg;
    start_next   = 1'b0;
    op_next      = MULTU;
    we_next      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state_reg)
      IDLE: begin
        if (ID2EX_MulDiv && ready_reg && reset) begin
          start_next   = 1'b1;
          op_next      = hilo_op(ID2EX_IsDiv, ID2EX_Signed);
          cnt_load     = 1'b1;
          cnt_load_val = ID2EX_IsDiv ? DIV_LOAD : MUL_LOAD;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        // A new ID2EX_MulDiv here is a protocol violation and is ignored.
        if (early_done || cnt_zero) begin
          state_next = WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WB: begin
        we_next    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even mid-operation.
  assign dep_in_id  = IF2ID_ReadHiLo | IF2ID_WriteHiLo | IF2ID_MulDiv;
  assign unit_start = start_next;
  assign unit_op    = op_next;
  assign hilo_we    = we_next & reset;
  assign busy       = (state_reg != IDLE) & reset;
  assign stall      = (busy | unit_start) & dep_in_id;

endmodule

// File: tb/tb_hilo_scheduler.sv
// tb_hilo_scheduler: directed cycle-accurate checks of hilo_scheduler.
module tb_hilo_scheduler;

  logic       clk;
  logic       reset;
  logic       ID2EX_MulDiv;
  logic       ID2EX_IsDiv;
  logic       ID2EX_Signed;
  logic       IF2ID_ReadHiLo;
  logic       IF2ID_WriteHiLo;
  logic       IF2ID_MulDiv;
  logic       unit_done;
  logic       unit_start;
  logic [1:0] unit_op;
  logic       hilo_we;
  logic       busy;
  logic       stall;

  int checks = 0;
  int errors = 0;

  hilo_scheduler #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID2EX_MulDiv    (ID2EX_MulDiv),
    .ID2EX_IsDiv     (ID2EX_IsDiv),
    .ID2EX_Signed    (ID2EX_Signed),
    .IF2ID_ReadHiLo  (IF2ID_ReadHiLo),
    .IF2ID_WriteHiLo (IF2ID_WriteHiLo),
    .IF2ID_MulDiv    (IF2ID_MulDiv),
    .unit_done       (unit_done),
    .unit_start      (unit_start),
    .unit_op         (unit_op),
    .hilo_we         (hilo_we),
    .busy            (busy),
    .stall           (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID2EX_MulDiv    = 1'b0;
    ID2EX_IsDiv     = 1'b0;
    ID2EX_Signed    = 1'b0;
    IF2ID_ReadHiLo  = 1'b0;
    IF2ID_WriteHiLo = 1'b0;
    IF2ID_MulDiv    = 1'b0;
    unit_done       = 1'b0;
  endtask

  // Reset held with a launch request pending, then the first free cycle.
  task automatic test_reset();
    reset = 1'b0;
    ID2EX_MulDiv   = 1'b1;
    ID2EX_IsDiv    = 1'b1;
    ID2EX_Signed   = 1'b1;
    IF2ID_ReadHiLo = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        reset = 1'b1;
        clear_inputs();
      end
      @(negedge clk);
      checks++;
      if ({unit_start, unit_op, hilo_we, busy, stall} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got start=%b op=%b we=%b busy=%b stall=%b want all 0",
                 k, unit_start, unit_op, hilo_we, busy, stall);
      end
      @(posedge clk); #1;
    end
    $display("reset: outputs held low during and after reset");
  endtask

  // Signed multiply, no dependent instruction in ID.
  task automatic test_mult();
    logic       e_start, e_busy, e_we;
    logic [1:0] e_op;
    for (int k = 0; k <= 7; k++) begin
      ID2EX_MulDiv = (k == 0);
      ID2EX_IsDiv  = 1'b0;
      ID2EX_Signed = (k == 0);
      @(negedge clk);
      e_start = (k == 0);
      e_op    = (k == 0) ? 2'b01 : 2'b00;
      e_busy  = (k >= 1) && (k <= 5);
      e_we    = (k == 5);
      checks += 5;
      if (unit_start !== e_start) begin
        errors++;
        $display("FAIL mult_start k=%0d got %b want %b", k, unit_start, e_start);
      end
      if (unit_op !== e_op) begin
        errors++;
        $display("FAIL mult_op k=%0d got %b want %b", k, unit_op, e_op);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL mult_busy k=%0d got %b want %b", k, busy, e_busy);
      end
      if (hilo_we !== e_we) begin
        errors++;
        $display("FAIL mult_we k=%0d got %b want %b", k, hilo_we, e_we);
      end
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL mult_stall k=%0d got %b want 0", k, stall);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    $display("mult: op=01 latency 4, commit at T+5");
  endtask

  // Signed divide with mfhi waiting in ID.
  task automatic test_mfhi_div();
    logic e_start, e_busy, e_we, e_stall;
    for (int k = 0; k <= 34; k++) begin
      ID2EX_MulDiv   = (k == 0);
      ID2EX_IsDiv    = (k == 0);
      ID2EX_Signed   = (k == 0);
      IF2ID_ReadHiLo = 1'b1;
      @(negedge clk);
      e_start = (k == 0);
      e_busy  = (k >= 1) && (k <= 33);
      e_we    = (k == 33);
      e_stall = (k <= 33);
      checks += 4;
      if (unit_start !== e_start) begin
        errors++;
        $display("FAIL div_start k=%0d got %b want %b", k, unit_start, e_start);
      end
      if (k == 0 && unit_op !== 2'b11) begin
        errors++;
        $display("FAIL div_op got %b want 11", unit_op);
      end
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL div_busy k=%0d got %b want %b", k, busy, e_busy);
      end
      if (hilo_we !== e_we) begin
        errors++;
        $display("FAIL div_we k=%0d got %b want %b", k, hilo_we, e_we);
      end
      if (stall !== e_stall) begin
        errors++;
        $display("FAIL div_stall k=%0d got %b want %b", k, stall, e_stall);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    $display("mfhi_div: stall 0..33, commit at 33, release at 34");
  endtask

  // Two multu back to back; EX request held high through BUSY/WB (ignored).
  task automatic test_back_to_back();
    logic e_start, e_stall, e_we;
    for (int k = 0; k <= 12; k++) begin
      ID2EX_MulDiv = (k <= 6);
      ID2EX_IsDiv  = 1'b0;
      ID2EX_Signed = 1'b0;
      IF2ID_MulDiv = (k <= 5);
      @(negedge clk);
      e_start = (k == 0) || (k == 6);
      e_stall = (k <= 5);
      e_we    = (k == 5) || (k == 11);
      checks += 3;
      if (unit_start !== e_start) begin
        errors++;
        $display("FAIL b2b_start k=%0d got %b want %b", k, unit_start, e_start);
      end
      if (stall !== e_stall) begin
        errors++;
        $display("FAIL b2b_stall k=%0d got %b want %b", k, stall, e_stall);
      end
      if (hilo_we !== e_we) begin
        errors++;
        $display("FAIL b2b_we k=%0d got %b want %b", k, hilo_we, e_we);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    $display("back_to_back: second multu launched at T+6");
  endtask

  // Reset lands in the middle of a divide.
  task automatic test_reset_mid();
    for (int k = 0; k <= 40; k++) begin
      ID2EX_MulDiv   = (k == 0);
      ID2EX_IsDiv    = (k == 0);
      ID2EX_Signed   = 1'b0;
      IF2ID_ReadHiLo = 1'b1;
      reset          = (k != 5);
      @(negedge clk);
      checks += 2;
      if (hilo_we !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_we k=%0d got %b want 0", k, hilo_we);
      end
      if (k >= 5) begin
        checks += 2;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_busy k=%0d got %b want 0", k, busy);
        end
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_stall k=%0d got %b want 0", k, stall);
        end
      end else if (stall !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_prestall k=%0d got %b want 1", k, stall);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    reset = 1'b1;
    $display("reset_mid: divide discarded, no commit");
  endtask

  // unit_done pulsed at T+3 during a divide.
  task automatic test_early_done();
    int we_at;
    int last;
`ifdef HILO_EARLY_DONE_EN
    we_at = 4;
`else
    we_at = 33;
`endif
    last = we_at + 1;
    for (int k = 0; k <= last; k++) begin
      ID2EX_MulDiv = (k == 0);
      ID2EX_IsDiv  = (k == 0);
      ID2EX_Signed = (k == 0);
      unit_done    = (k == 3);
      @(negedge clk);
      checks += 2;
      if (hilo_we !== (k == we_at)) begin
        errors++;
        $display("FAIL early_we k=%0d got %b want %b", k, hilo_we, (k == we_at));
      end
      if (busy !== (k >= 1 && k <= we_at)) begin
        errors++;
        $display("FAIL early_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= we_at));
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    $display("early_done: commit at T+%0d", we_at);
  endtask

  // Unsigned multiply with an independent instruction (add) in ID.
  task automatic test_independent();
    for (int k = 0; k <= 6; k++) begin
      ID2EX_MulDiv = (k == 0);
      @(negedge clk);
      checks += 2;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL indep_stall k=%0d got %b want 0", k, stall);
      end
      if (busy !== (k >= 1 && k <= 5)) begin
        errors++;
        $display("FAIL indep_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= 5));
      end
      if (k == 0) begin
        checks++;
        if (unit_op !== 2'b00) begin
          errors++;
          $display("FAIL indep_op got %b want 00", unit_op);
        end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    $display("independent: add in ID never stalled");
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_mfhi_div();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #1;
    test_early_done();
    test_independent();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_scheduler.md
# hilo_scheduler

Sequencer for the multi-cycle multiply/divide unit that owns the HI/LO registers. Sits beside the forwarding and load-use hazard logic in EX. Launches the unit when a mult/multu/div/divu enters EX, counts its latency, and commits the result to HI/LO. Stalls the front of the pipeline while any instruction in ID depends on HI/LO or on the busy unit; `stall` is ORed with the load-use stall at the top level.

## Interface

**Parameters**
- `MUL_CYCLES`, default 4: execution cycles for mult/multu. Legal range 1..63.
- `DIV_CYCLES`, default 32: execution cycles for div/divu. Legal range 1..63.

**Ports**
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low.
- `ID2EX_MulDiv` in 1: instruction now in EX is a mult/multu/div/divu.
- `ID2EX_IsDiv` in 1: the EX instruction is a divide (0 = multiply).
- `ID2EX_Signed` in 1: signed variant.
- `IF2ID_ReadHiLo` in 1: instruction in ID is mfhi/mflo.
- `IF2ID_WriteHiLo` in 1: instruction in ID is mthi/mtlo.
- `IF2ID_MulDiv` in 1: instruction in ID is mult/multu/div/divu.
- `unit_done` in 1: early-completion flag from the unit (see Configuration).
- `unit_start` out 1: one-cycle launch pulse to the unit.
- `unit_op` out 2: {IsDiv, Signed}; valid while `unit_start` is high.
- `hilo_we` out 1: one-cycle write enable committing the unit result to HI/LO.
- `busy` out 1: a unit operation is in flight.
- `stall` out 1: hold PC and IF/ID, insert a bubble into ID/EX.

## Operation

**States:** IDLE, BUSY, WB. Down-counter `cnt`, 6 bits.

**IDLE**
- If `ID2EX_MulDiv`=1: assert `unit_start` combinationally this cycle, drive `unit_op`, load `cnt` with N-1 (N = `DIV_CYCLES` or `MUL_CYCLES`), then go to BUSY.
- Otherwise remain in IDLE.

**BUSY**
- If `cnt`==0: go to WB.
- Otherwise decrement `cnt`.

**WB**
- `hilo_we`=1 for this cycle, then go to IDLE.
- A new `ID2EX_MulDiv` in WB is not accepted. The stall guarantees it cannot occur.

**Outputs**
- `busy` = (state != IDLE).
- `stall` = (`busy` | `unit_start`) & (`IF2ID_ReadHiLo` | `IF2ID_WriteHiLo` | `IF2ID_MulDiv`).
- An mfhi in ID is released on the cycle after WB, so it reads the committed HI/LO.

**Protocol violation**
- `ID2EX_MulDiv`=1 while in BUSY or WB is ignored: no restart, no second start pulse.

**Reset**
- Applied at any time, including mid-operation, it forces IDLE and `cnt`=0.
- All outputs read 0 during reset and in the first cycle after it.
- The in-flight result is discarded and no `hilo_we` is issued.
- The top level resets the unit with the same `reset`.

## Timing

- Launch in cycle T: `unit_start` at T.
- `busy`=1 for cycles T+1 .. T+N+1.
- `hilo_we` at T+N+1.
- Back-to-back operations: the earliest next `unit_start` is T+N+2.
- `stall` for a dependent ID instruction is high from T through T+N+1 inclusive, and low at T+N+2.
- Reset values: `unit_start`=0, `unit_op`=0, `hilo_we`=0, `busy`=0, `stall`=0.

## Configuration

- **`HILO_EARLY_DONE_EN` defined:** in BUSY, `unit_done`=1 forces the transition to WB on the next edge regardless of `cnt`. This supports a divider with early termination. `unit_done` is ignored in IDLE and WB.
- **Not defined:** `unit_done` is unused and completion is strictly count-based.

## Structure

- **Package `hilo_pkg`:**
  - State enum `hilo_state_t` {IDLE, BUSY, WB}.
  - `unit_op` encodings: MULTU=2'b00, MULT=2'b01, DIVU=2'b10, DIV=2'b11.
  - Counter width constant `HILO_CNT_W`=6.
- **Sub-module `hilo_cycle_counter`:** loadable down-counter with a zero flag. Instantiated once.

## Test plan

- **Multiply, default parameters:** mult enters EX at cycle 10 → `unit_start`=1 and `unit_op`=2'b01 at 10; `busy` high 11–15; `hilo_we`=1 only at 15.
- **mfhi behind div:** div in EX at cycle 0 with mfhi in ID → `stall`=1 cycles 0–33; `hilo_we` at 33; `stall`=0 at 34.
- **Back-to-back multu:** multu issued, then multu in ID → `stall` holds the second multu; its `unit_start` occurs exactly at T+6.
- **Reset mid-divide:** `reset`=0 at T+5 → next cycle `busy`=0 and `stall`=0; `hilo_we` never pulses.
- **Early done (with `HILO_EARLY_DONE_EN`):** div at T, `unit_done` at T+3 → `hilo_we` at T+4; without the macro, `hilo_we` at T+33.
- **Independent instruction:** add in ID during BUSY → `stall`=0 throughout.
